// File: rtl/mem_dma_if.sv
// Memory request/response bus between the DMA engine (master) and a memory.
// The response is combinational: code/data are valid in the same cycle as the request.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

interface mem_dma_if #(
  parameter int ADDR_W      = `ADDR_W,
  parameter int WORD_W      = `WORD_W,
  parameter int MEM_COUNT_W = `MEM_COUNT_W,
  parameter int MEM_CODE_W  = `MEM_CODE_W
);
  logic [ADDR_W-1:0]      o_req_addr;
  logic [WORD_W-1:0]      o_req_wr_data;
  logic                   o_req_wr_en;
  logic [MEM_COUNT_W-1:0] o_req_count;
  logic [WORD_W-1:0]      i_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_res_code;

  modport master (
    output o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count,
    input  i_res_rd_data, i_res_code
  );
  modport slave (
    input  o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count,
    output i_res_rd_data, i_res_code
  );
endinterface

// File: rtl/mem_dma.sv
// Word-by-word memory copy engine: one read cycle then one write cycle per word,
// stopping on completion, abort (at a word boundary) or the first bus fault.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

module mem_dma #(
  parameter int ADDR_W      = `ADDR_W,
  parameter int WORD_W      = `WORD_W,
  parameter int MEM_COUNT_W = `MEM_COUNT_W,
  parameter int MEM_CODE_W  = `MEM_CODE_W,
  parameter int LEN_W       = 16,
  parameter int WORD_BYTES  = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  mem_dma_if.master         bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [LEN_W-1:0]  o_words_done
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q, err_addr_q;
  logic [LEN_W-1:0]  rem_q, words_q;
  logic [WORD_W-1:0] buf_q;
  logic              err_q;

  logic in_rd, in_wr, fault;
  assign in_rd = (state_q == RD);
  assign in_wr = (state_q == WR);
  assign fault = (bus.i_res_code != '0);

  // Bus is decoded purely from registered state, so it is idle outside RD/WR.
  assign bus.o_req_addr    = in_wr ? dst_q : (in_rd ? src_q : '0);
  assign bus.o_req_wr_en   = in_wr;
  assign bus.o_req_count   = (in_rd || in_wr) ? MEM_COUNT_W'(WORD_BYTES) : '0;
  assign bus.o_req_wr_data = in_wr ? buf_q : '0;

  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == FIN);
  assign o_error      = err_q;
  assign o_err_addr   = err_addr_q;
  assign o_words_done = words_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      words_q    <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          src_q      <= i_src_addr;
          dst_q      <= i_dst_addr;
          rem_q      <= i_len;
          words_q    <= '0;
          err_q      <= 1'b0;
          err_addr_q <= '0;
          state_q    <= (i_len == '0) ? FIN : RD;
        end
        // A fault outranks abort so the faulting address is never lost.
        RD: begin
          if (fault) begin
            err_q      <= 1'b1;
            err_addr_q <= src_q;
            state_q    <= FIN;
          end else if (i_abort) begin
            state_q <= FIN;
          end else begin
            buf_q   <= bus.i_res_rd_data;
            state_q <= WR;
          end
        end
        WR: begin
          if (fault) begin
            err_q      <= 1'b1;
            err_addr_q <= dst_q;
            state_q    <= FIN;
          end else begin
            src_q   <= src_q + STRIDE;
            dst_q   <= dst_q + STRIDE;
            words_q <= words_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            state_q <= (rem_q == LEN_W'(1) || i_abort) ? FIN : RD;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 Parameter ADDR_W, default `ADDR_W, request address width.
REQ-002 Parameter WORD_W, default `WORD_W, data word width.
REQ-003 Parameter MEM_COUNT_W, default `MEM_COUNT_W, request byte-count width.
REQ-004 Parameter MEM_CODE_W, default `MEM_CODE_W, response code width.
REQ-005 Parameter LEN_W, default 16, transfer length width in words.
REQ-006 Parameter WORD_BYTES, default 4, bytes per word; this is the address stride and the o_req_count value.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 areset  in  1  asynchronous, active-high reset.
REQ-009 i_start  in  1  one-cycle pulse: latch src/dst/len, begin transfer.
REQ-010 i_src_addr  in  ADDR_W  first source word address; i_dst_addr  in  ADDR_W  first destination word address.
REQ-011 i_len  in  LEN_W  words to copy.
REQ-012 i_abort  in  1  stop the transfer at the next word boundary.
REQ-013 o_req_addr  out  ADDR_W; o_req_wr_data  out  WORD_W; o_req_wr_en  out  1; o_req_count  out  MEM_COUNT_W  bus request; count 0 = no access.
REQ-014 i_res_rd_data  in  WORD_W; i_res_code  in  MEM_CODE_W  combinational same-cycle response; code 0 = OK, nonzero = fault.
REQ-015 o_busy  out  1; o_done  out  1  one-cycle completion pulse; o_error  out  1  sticky fault flag; o_err_addr  out  ADDR_W  faulting address; o_words_done  out  LEN_W  words written.

Function
REQ-016 States SHALL be IDLE, RD, WR, FIN.
REQ-017 In IDLE, o_req_count SHALL be 0, o_req_wr_en 0, o_req_addr 0, o_req_wr_data 0.
REQ-018 i_start in IDLE with i_len>0 SHALL latch the operands, clear o_error/o_err_addr/o_words_done, and go to RD next cycle.
REQ-019 i_start in IDLE with i_len==0 SHALL clear the status fields, go to FIN, and issue no bus access.
REQ-020 i_start while not IDLE SHALL be ignored.
REQ-021 In RD: o_req_addr=src, wr_en=0, count=WORD_BYTES; at the edge, if code==0, capture i_res_rd_data into the data buffer and go to WR.
REQ-022 In WR: o_req_addr=dst, wr_en=1, count=WORD_BYTES, wr_data=buffer; at the edge, if code==0, src+=WORD_BYTES, dst+=WORD_BYTES, o_words_done+=1, remaining-=1.
REQ-023 After an OK WR, go to FIN if remaining reaches 0 or i_abort is sampled high; otherwise go to RD.
REQ-024 Each word SHALL take exactly 2 cycles; an N-word transfer SHALL set o_busy high for 2N cycles plus 1 FIN cycle.
REQ-025 A nonzero i_res_code in RD or WR SHALL set o_error=1 and o_err_addr=the current request address, perform no capture or increment, and go to FIN.
REQ-026 i_abort sampled high in RD SHALL go to FIN without capture; in WR it SHALL complete that write first.
REQ-027 If a fault and i_abort occur in the same cycle, the fault SHALL be recorded.
REQ-028 Address increments SHALL wrap modulo 2^ADDR_W without an error.
REQ-029 FIN SHALL assert o_done for one cycle, drive an idle bus, and return to IDLE.
REQ-030 o_busy SHALL be 1 in RD, WR and FIN, and 0 in IDLE.
REQ-031 o_error, o_err_addr and o_words_done SHALL hold their values until the next accepted i_start.

Reset
REQ-032 While areset is high, regardless of clk: state=IDLE, all outputs 0, buffer/counters 0.
REQ-033 areset asserted mid-transfer SHALL abandon the transfer immediately, with no o_done pulse.
REQ-034 After areset deasserts, the first accepted i_start SHALL be honoured on the next clk edge.

Verification
REQ-035 src=0x100, dst=0x200, len=3, memory model OK -> reads 0x100/104/108 and writes 0x200/204/208 alternating, data copied, o_busy 7 cycles, o_done once, o_words_done=3.
REQ-036 len=0 -> no access with count≠0, o_done 1 cycle after start, o_error=0.
REQ-037 len=4, code=1 on the read of src+8 -> o_error=1, o_err_addr=src+8, o_words_done=2, o_done pulses, then IDLE.
REQ-038 len=5, i_abort during the 2nd WR -> the 2nd write completes, o_words_done=2, o_done pulses.
REQ-039 src=2^ADDR_W-4, len=2 -> second read at address 0, no error.
REQ-040 areset pulsed during WR of a 4-word transfer -> all outputs 0 immediately, no o_done; new start with len=1 then completes normally.
